// File: rtl/uart_app_pkg.sv
// Shared constants and FSM encoding for the JTAG UART application controller.
// Default characters match the banner / trigger / fill / terminator protocol.
package uart_app_pkg;

  localparam int unsigned CHAR_W = 8;

  localparam logic [CHAR_W-1:0] DEF_BANNER_CH = 8'd83;  // 'S'
  localparam logic [CHAR_W-1:0] DEF_TRIG_CH   = 8'd97;  // 'a'
  localparam logic [CHAR_W-1:0] DEF_FILL_CH   = 8'd66;  // 'B'
  localparam logic [CHAR_W-1:0] DEF_END_CH    = 8'd67;  // 'C'

  typedef enum logic [2:0] {
    S_BANNER = 3'd0,
    S_IDLE   = 3'd1,
    S_CAPT   = 3'd2,
    S_ECHO   = 3'd3,
    S_BURST  = 3'd4,
    S_END    = 3'd5,
    S_GAP    = 3'd6
  } state_e;

  // A zero-length burst still needs a 1-bit counter to compare against.
  function automatic int unsigned fill_width(int unsigned len);
    return (len == 0) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/uart_tx_gate.sv
// Issues a single-cycle active-low write strobe to the UART TX FIFO when a
// request is pending and the FIFO is not full; done marks the write cycle.
module uart_tx_gate #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          req_i,
  input  logic [DW-1:0] ch_i,
  input  logic          txfl_i,
  output logic          nwr_o,
  output logic [DW-1:0] data_o,
  output logic          done_o
);

  logic armed_q;
  logic fire;

  // Writes are held off until the first clock after reset release so the
  // strobe is guaranteed inactive while reset is asserted.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  assign fire   = armed_q & req_i & ~txfl_i;
  assign nwr_o  = ~fire;
  assign data_o = fire ? ch_i : '0;
  assign done_o = fire;

endmodule

// File: rtl/uart_burst_echo_ctrl.sv
// JTAG UART application controller: banner after reset, echo of received
// characters, and a fill burst plus terminator on a trigger character.
module uart_burst_echo_ctrl
  import uart_app_pkg::*;
#(
  parameter int unsigned   DW        = CHAR_W,
  parameter int unsigned   BURST_LEN = 4095,
  parameter logic [DW-1:0] BANNER_CH = DW'(DEF_BANNER_CH),
  parameter logic [DW-1:0] TRIG_CH   = DW'(DEF_TRIG_CH),
  parameter logic [DW-1:0] FILL_CH   = DW'(DEF_FILL_CH),
  parameter logic [DW-1:0] END_CH    = DW'(DEF_END_CH),
  parameter bit            ECHO_EN   = 1'b1,
  parameter int unsigned   CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  output logic             nwr_o,
  output logic [DW-1:0]    data_o,
  output logic             rd_o,
  input  logic [DW-1:0]    data_i,
  input  logic             txfl_i,
  input  logic             rxmt_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] rx_cnt_o,
  output logic [7:0]       burst_cnt_o
);

  localparam int unsigned       FILL_W    = fill_width(BURST_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(BURST_LEN);

  state_e             state_q, state_d;
  logic [DW-1:0]      rx_ch_q;
  logic [CNT_W-1:0]   rx_cnt_q;
  logic [7:0]         burst_cnt_q;
  logic [FILL_W-1:0]  fill_q;
  logic               busy_q;

  logic               tx_req;
  logic [DW-1:0]      tx_ch;
  logic               tx_done;

  uart_tx_gate #(
    .DW (DW)
  ) u_tx_gate (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .req_i    (tx_req),
    .ch_i     (tx_ch),
    .txfl_i   (txfl_i),
    .nwr_o    (nwr_o),
    .data_o   (data_o),
    .done_o   (tx_done)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_BANNER;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BANNER: if (tx_done) state_d = S_GAP;
      S_IDLE:   if (!rxmt_i) state_d = S_CAPT;
      S_CAPT: begin
        if (data_i == TRIG_CH) begin
          state_d = S_BURST;
        end else if (ECHO_EN) begin
          state_d = S_ECHO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ECHO:   if (tx_done) state_d = S_GAP;
      S_BURST: begin
        if (fill_q == FILL_LAST) begin
          state_d = S_END;
        end else if (tx_done) begin
          state_d = S_GAP;
        end
      end
      S_END:    if (tx_done) state_d = S_GAP;
      // busy is cleared by the terminator write, so it tells fill gaps apart.
      S_GAP:    state_d = busy_q ? S_BURST : S_IDLE;
      default:  state_d = S_BANNER;
    endcase
  end

  always_comb begin
    tx_req = 1'b0;
    tx_ch  = rx_ch_q;
    rd_o   = 1'b0;
    unique case (state_q)
      S_BANNER: begin
        tx_req = 1'b1;
        tx_ch  = BANNER_CH;
      end
      S_IDLE:   rd_o = ~rxmt_i;
      S_ECHO:   tx_req = 1'b1;
      S_BURST: begin
        tx_req = (fill_q != FILL_LAST);
        tx_ch  = FILL_CH;
      end
      S_END: begin
        tx_req = 1'b1;
        tx_ch  = END_CH;
      end
      default: begin
        tx_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rx_ch_q     <= '0;
      rx_cnt_q    <= '0;
      burst_cnt_q <= '0;
      fill_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (state_q == S_CAPT) begin
        rx_ch_q  <= data_i;
        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
        if (data_i == TRIG_CH) begin
          busy_q <= 1'b1;
          fill_q <= '0;
        end
      end
      if (state_q == S_BURST && tx_done) begin
        fill_q <= fill_q + FILL_W'(1);
      end
      if (state_q == S_END && tx_done) begin
        busy_q      <= 1'b0;
        burst_cnt_q <= burst_cnt_q + 8'd1;
      end
    end
  end

  assign busy_o      = busy_q;
  assign rx_cnt_o    = rx_cnt_q;
  assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_uart_burst_echo_ctrl.sv
// Bench for uart_burst_echo_ctrl: two instances (echo with 4-char bursts, and
// no echo with terminator-only bursts) against a character-stream model.
module tb_uart_burst_echo_ctrl;

  localparam int unsigned TX_DEPTH = 4;
  localparam logic [7:0]  BANNER   = 8'd83;
  localparam logic [7:0]  TRIG     = 8'd97;
  localparam logic [7:0]  FILL     = 8'd66;
  localparam logic [7:0]  ENDC     = 8'd67;

  logic        clk = 1'b0;
  logic        nreset;
  logic        nwr       [2];
  logic        rd        [2];
  logic        busy      [2];
  logic        txfl      [2];
  logic        rxmt      [2];
  logic [7:0]  dout      [2];
  logic [7:0]  din       [2];
  logic [15:0] rx_cnt    [2];
  logic [7:0]  burst_cnt [2];

  always #5 clk = ~clk;

  uart_burst_echo_ctrl #(
    .BURST_LEN (4),
    .ECHO_EN   (1'b1)
  ) u_dut0 (
    .clk_i       (clk),
    .nreset_i    (nreset),
    .nwr_o       (nwr[0]),
    .data_o      (dout[0]),
    .rd_o        (rd[0]),
    .data_i      (din[0]),
    .txfl_i      (txfl[0]),
    .rxmt_i      (rxmt[0]),
    .busy_o      (busy[0]),
    .rx_cnt_o    (rx_cnt[0]),
    .burst_cnt_o (burst_cnt[0])
  );

  uart_burst_echo_ctrl #(
    .BURST_LEN (0),
    .ECHO_EN   (1'b0)
  ) u_dut1 (
    .clk_i       (clk),
    .nreset_i    (nreset),
    .nwr_o       (nwr[1]),
    .data_o      (dout[1]),
    .rd_o        (rd[1]),
    .data_i      (din[1]),
    .txfl_i      (txfl[1]),
    .rxmt_i      (rxmt[1]),
    .busy_o      (busy[1]),
    .rx_cnt_o    (rx_cnt[1]),
    .burst_cnt_o (burst_cnt[1])
  );

  // Environment: RX FIFO contents, TX FIFO fill level, expected TX stream.
  logic [7:0] rxbuf    [2][256];
  int         rx_head  [2];
  int         rx_tail  [2];
  logic [7:0] exp_ch   [2][4096];
  int         exp_kind [2][4096];  // 0 banner/echo, 1 fill, 2 terminator
  int         exp_wr   [2];
  int         exp_rd   [2];
  int         txc      [2];
  int         hold     [2];
  bit         prev_wr  [2];
  bit         after_end[2];
  bit         wr_now   [2];
  bit         rd_now   [2];
  bit         await_wr [2];
  int         rd_cyc   [2];
  int         lat      [2];
  int         busy_cycles[2];
  int         rd_count [2];
  int         fills_seen[2];
  int         pushed   [2];
  int         trigs    [2];
  int         cyc;
  int         drain_pct;
  bit         t4_arm;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int blen(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic bit echo_en(input int i);
    return (i == 0);
  endfunction

  task automatic expect_tx(input int i, input logic [7:0] ch, input int kind);
    exp_ch[i][exp_wr[i] & 4095]   = ch;
    exp_kind[i][exp_wr[i] & 4095] = kind;
    exp_wr[i]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      rxmt[i] = (rx_head[i] == rx_tail[i]);
      txfl[i] = (txc[i] >= int'(TX_DEPTH)) || (hold[i] > 0);
    end
  endtask

  // Reference model: each received char maps directly to its TX output.
  task automatic push_rx(input int i, input logic [7:0] c);
    rxbuf[i][rx_tail[i] & 255] = c;
    rx_tail[i]++;
    pushed[i]++;
    if (c == TRIG) begin
      trigs[i]++;
      for (int k = 0; k < blen(i); k++) expect_tx(i, FILL, 1);
      expect_tx(i, ENDC, 2);
    end else if (echo_en(i)) begin
      expect_tx(i, c, 0);
    end
    drive_inputs();
  endtask

  task automatic reset_env();
    for (int i = 0; i < 2; i++) begin
      rx_head[i] = 0;  rx_tail[i] = 0;
      exp_wr[i] = 0;   exp_rd[i] = 0;
      txc[i] = 0;      hold[i] = 0;
      prev_wr[i] = 0;  after_end[i] = 0;
      await_wr[i] = 1; rd_cyc[i] = 0;   lat[i] = 99;
      busy_cycles[i] = 0; rd_count[i] = 0; fills_seen[i] = 0;
      pushed[i] = 0;   trigs[i] = 0;
      din[i] = 8'd0;
      expect_tx(i, BANNER, 0);
    end
    cyc = 0;
    drive_inputs();
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_nwr"},   nwr[i],       1);
      check_eq({tag, "_rd"},    rd[i],        0);
      check_eq({tag, "_data"},  dout[i],      0);
      check_eq({tag, "_busy"},  busy[i],      0);
      check_eq({tag, "_rxcnt"}, rx_cnt[i],    0);
      check_eq({tag, "_bcnt"},  burst_cnt[i], 0);
    end
  endtask

  // One clock: sample on the falling edge, update the FIFO models after the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      wr_now[i] = !nwr[i];
      rd_now[i] = rd[i];
      if (busy[i]) busy_cycles[i]++;
      if (after_end[i]) begin
        check_eq("busy_fall", busy[i], 0);
        after_end[i] = 0;
      end
      if (wr_now[i]) begin
        check_eq("wr_full", txfl[i], 0);
        check_eq("wr_gap", prev_wr[i], 0);
        check_eq("tx_pending", exp_wr[i] > exp_rd[i], 1);
        if (exp_wr[i] > exp_rd[i]) begin
          check_eq("tx_char", dout[i], exp_ch[i][exp_rd[i] & 4095]);
          check_eq("tx_busy", busy[i], exp_kind[i][exp_rd[i] & 4095] != 0);
          if (exp_kind[i][exp_rd[i] & 4095] == 1) fills_seen[i]++;
          if (exp_kind[i][exp_rd[i] & 4095] == 2) begin
            fills_seen[i] = 0;
            after_end[i] = 1;
          end
          exp_rd[i]++;
        end
        if (await_wr[i]) begin
          lat[i] = cyc - rd_cyc[i];
          await_wr[i] = 0;
        end
      end
      if (rd_now[i]) begin
        check_eq("rd_empty", rxmt[i], 0);
        check_eq("rd_busy", busy[i], 0);
        rd_cyc[i] = cyc;
        await_wr[i] = 1;
        rd_count[i]++;
      end
      prev_wr[i] = wr_now[i];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (wr_now[i]) txc[i]++;
      if (rd_now[i] && rx_head[i] != rx_tail[i]) begin
        din[i] = rxbuf[i][rx_head[i] & 255];
        rx_head[i]++;
      end
      if (txc[i] > 0 && int'($urandom_range(99)) < drain_pct) txc[i]--;
      if (hold[i] > 0) hold[i]--;
    end
    if (t4_arm && fills_seen[0] == 2) begin
      hold[0] = 10;
      t4_arm = 0;
    end
    drive_inputs();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 2; i++) begin
      if (exp_rd[i] != exp_wr[i] || rx_head[i] != rx_tail[i] || busy[i]) return 0;
    end
    return 1;
  endfunction

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (!all_idle() && n < budget) begin
      cycle();
      n++;
    end
    check_eq(tag, all_idle(), 1);
    repeat (3) cycle();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    nreset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drain_pct = 100;
    t4_arm = 0;
    nreset = 1'b0;
    reset_env();
    #12;
    check_reset_vals("rst");

    // Banner after release, no reads while RX is empty
    release_reset();
    repeat (5) cycle();
    for (int i = 0; i < 2; i++) begin
      check_eq("banner_sent", exp_rd[i], 1);
      check_eq("banner_lat", lat[i] <= 2, 1);
      check_eq("rd_idle", rd_count[i], 0);
    end

    // Echo of 'x' (discarded by the no-echo instance)
    push_rx(0, 8'd120);
    push_rx(1, 8'd120);
    run_until_idle(50, "t2_idle");
    check_eq("echo_lat", lat[0], 2);
    check_eq("echo_rxcnt0", rx_cnt[0], 1);
    check_eq("echo_rxcnt1", rx_cnt[1], 1);
    check_eq("noecho_writes", exp_rd[1], 1);

    // Trigger: 4 fills + terminator, and terminator-only burst
    for (int i = 0; i < 2; i++) busy_cycles[i] = 0;
    push_rx(0, TRIG);
    push_rx(1, TRIG);
    run_until_idle(100, "t3_idle");
    check_eq("burst_lat0", lat[0], 2);
    check_eq("burst_lat1", lat[1], 3);
    check_eq("busy_len1", busy_cycles[1], 2);
    check_eq("bcnt0", burst_cnt[0], 1);
    check_eq("bcnt1", burst_cnt[1], 1);

    // TX full for 10 cycles after the second fill
    t4_arm = 1;
    push_rx(0, TRIG);
    run_until_idle(100, "t4_idle");
    check_eq("t4_stalled", t4_arm, 0);
    check_eq("t4_bcnt", burst_cnt[0], 2);

    // Asynchronous reset in the middle of a burst
    push_rx(0, TRIG);
    begin
      int n = 0;
      while (fills_seen[0] < 1 && n < 20) begin
        cycle();
        n++;
      end
    end
    check_eq("t6_midburst", fills_seen[0] >= 1, 1);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("t6_hold");
    reset_env();
    release_reset();
    repeat (5) cycle();
    for (int i = 0; i < 2; i++) begin
      check_eq("t6_banner", exp_rd[i], 1);
      check_eq("t6_banner_lat", lat[i] <= 2, 1);
      check_eq("t6_bcnt", burst_cnt[i], 0);
    end

    // Randomized traffic with TX back-pressure
    drain_pct = 40;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(99) < 3) hold[i] = int'($urandom_range(6));
        if ((rx_tail[i] - rx_head[i]) < 8 && $urandom_range(99) < 25) begin
          if ($urandom_range(99) < 20) push_rx(i, TRIG);
          else push_rx(i, 8'($urandom_range(255)));
        end
      end
      drive_inputs();
      cycle();
    end
    drain_pct = 100;
    run_until_idle(3000, "rand_idle");
    for (int i = 0; i < 2; i++) begin
      check_eq("rand_rxcnt", rx_cnt[i], pushed[i] & 16'hffff);
      check_eq("rand_bcnt", burst_cnt[i], trigs[i] & 8'hff);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
